// File: rtl/gpio_bank.sv
// Memory-mapped GPIO bank: per-pin direction, atomic set/clear, synchronised inputs, edge interrupts.
// One-cycle io latency (io_ready pulses the cycle after accept); a held io_valid is accepted every other edge.
module gpio_bank #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             io_valid,
    input  logic [31:0]      io_addr,
    input  logic [31:0]      io_wdata,
    input  logic [3:0]       io_wstrb,
    output logic             io_ready,
    output logic [31:0]      io_rdata,
    input  logic [WIDTH-1:0] gpio_in,
    output logic [WIDTH-1:0] gpio_out,
    output logic [WIDTH-1:0] gpio_oe,
    output logic             irq
);

    localparam int CW = $clog2(SYNC_STAGES + 2);

    localparam logic [2:0] A_OUT  = 3'd0;
    localparam logic [2:0] A_DIR  = 3'd1;
    localparam logic [2:0] A_IN   = 3'd2;
    localparam logic [2:0] A_EN   = 3'd3;
    localparam logic [2:0] A_STAT = 3'd4;
    localparam logic [2:0] A_POL  = 3'd5;
    localparam logic [2:0] A_SET  = 3'd6;
    localparam logic [2:0] A_CLR  = 3'd7;

    logic [WIDTH-1:0] out_q, out_d, dir_q, dir_d, en_q, en_d;
    logic [WIDTH-1:0] stat_q, stat_d, pol_q, pol_d, prev_q;
    logic [SYNC_STAGES-1:0][WIDTH-1:0] sync_q;
    logic [CW-1:0]    inh_q, inh_d;
    logic             ready_q, ready_d, irq_q, irq_d;
    logic [31:0]      rdata_q, rdata_d;

    logic             accept, wr;
    logic [2:0]       sel;
    logic [31:0]      bmask32;
    logic [WIDTH-1:0] wmask, wbits, sync, ev, rd_w;
    logic             unused_addr;

    assign sel         = io_addr[4:2];
    assign unused_addr = ^{io_addr[31:5], io_addr[1:0]};
    assign accept      = io_valid && !ready_q;
    assign wr          = accept && (io_wstrb != 4'b0000);
    assign bmask32     = {{8{io_wstrb[3]}}, {8{io_wstrb[2]}}, {8{io_wstrb[1]}}, {8{io_wstrb[0]}}};
    assign wmask       = bmask32[WIDTH-1:0];
    assign wbits       = io_wdata[WIDTH-1:0] & wmask;
    assign sync        = sync_q[SYNC_STAGES-1];

    // Held off while the inhibit counter runs so pins high through reset do not look like edges.
    assign ev = (inh_q != '0) ? '0
              : ((pol_q & prev_q & ~sync) | (~pol_q & sync & ~prev_q));

    always_comb begin
        out_d   = out_q;
        dir_d   = dir_q;
        en_d    = en_q;
        pol_d   = pol_q;
        stat_d  = stat_q;
        rdata_d = rdata_q;
        rd_w    = '0;
        inh_d   = (inh_q != '0) ? inh_q - CW'(1) : inh_q;
        irq_d   = |(stat_q & en_q);
        ready_d = accept;

        case (sel)
            A_OUT:   rd_w = out_q;
            A_DIR:   rd_w = dir_q;
            A_IN:    rd_w = sync;
            A_EN:    rd_w = en_q;
            A_STAT:  rd_w = stat_q;
            A_POL:   rd_w = pol_q;
            default: rd_w = '0;
        endcase

        if (wr) begin
            case (sel)
                A_OUT:  out_d  = (out_q & ~wmask) | wbits;
                A_DIR:  dir_d  = (dir_q & ~wmask) | wbits;
                A_IN:   ;
                A_EN:   en_d   = (en_q & ~wmask) | wbits;
                A_STAT: stat_d = stat_q & ~wbits;
                A_POL:  pol_d  = (pol_q & ~wmask) | wbits;
                A_SET:  out_d  = out_q | wbits;
                A_CLR:  out_d  = out_q & ~wbits;
                default: ;
            endcase
        end else if (accept) begin
            rdata_d            = '0;
            rdata_d[WIDTH-1:0] = rd_w;
        end

        // A new event overrides a same-cycle write-1-to-clear.
        stat_d = stat_d | ev;
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            out_q   <= '0;
            dir_q   <= '0;
            en_q    <= '0;
            stat_q  <= '0;
            pol_q   <= '0;
            sync_q  <= '0;
            prev_q  <= '0;
            inh_q   <= CW'(SYNC_STAGES + 1);
            ready_q <= 1'b0;
            rdata_q <= '0;
            irq_q   <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            en_q    <= en_d;
            stat_q  <= stat_d;
            pol_q   <= pol_d;
            sync_q  <= {sync_q[SYNC_STAGES-2:0], gpio_in};
            prev_q  <= sync;
            inh_q   <= inh_d;
            ready_q <= ready_d;
            rdata_q <= rdata_d;
            irq_q   <= irq_d;
        end
    end

    assign io_ready = ready_q;
    assign io_rdata = rdata_q;
    assign gpio_out = out_q;
    assign gpio_oe  = dir_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_gpio_bank.sv
// Directed bench for gpio_bank with a pin-history reference model checked every cycle.
module tb_gpio_bank;
    localparam int W = 32;
    localparam int S = 2;

    logic          clk = 1'b0;
    logic          resetn, io_valid, io_ready, irq;
    logic [31:0]   io_addr, io_wdata, io_rdata;
    logic [3:0]    io_wstrb;
    logic [W-1:0]  gpio_in, gpio_out, gpio_oe;

    always #5 clk = ~clk;

    gpio_bank #(.WIDTH(W), .SYNC_STAGES(S)) dut (
        .clk(clk), .resetn(resetn), .io_valid(io_valid), .io_addr(io_addr),
        .io_wdata(io_wdata), .io_wstrb(io_wstrb), .io_ready(io_ready),
        .io_rdata(io_rdata), .gpio_in(gpio_in), .gpio_out(gpio_out),
        .gpio_oe(gpio_oe), .irq(irq)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Reference model: registers by offset index, plus the raw history of sampled pins.
    logic [31:0] m_reg [8];
    logic [W-1:0] pin_hist [S+1];
    int          edges_up = 0;
    logic        m_rdy = 1'b0, m_irq = 1'b0;
    logic [31:0] m_rdata = '0;
    bit          m_live = 1'b0;

    always @(posedge clk) begin : model
        logic [31:0] nxt [8];
        logic [31:0] mask, wb, evv, s, p;
        int a;
        if (!resetn) begin
            for (int i = 0; i < 8; i++) m_reg[i] = '0;
            for (int k = 0; k <= S; k++) pin_hist[k] = '0;
            edges_up = 0;
            m_rdy    = 1'b0;
            m_rdata  = '0;
            m_irq    = 1'b0;
            m_live   = 1'b1;
        end else begin
            edges_up++;
            s   = pin_hist[S-1];
            p   = pin_hist[S];
            evv = '0;
            if (edges_up > S + 1)
                for (int i = 0; i < W; i++)
                    evv[i] = m_reg[5][i] ? (p[i] & ~s[i]) : (s[i] & ~p[i]);
            nxt   = m_reg;
            m_irq = |(m_reg[4] & m_reg[3]);
            if (io_valid && !m_rdy) begin
                a = int'(io_addr[4:2]);
                if (io_wstrb == 4'b0000) begin
                    m_rdata = (a == 2) ? s : m_reg[a];
                end else begin
                    mask = '0;
                    for (int b = 0; b < 4; b++)
                        if (io_wstrb[b]) mask = mask | (32'hFF << (8 * b));
                    wb = io_wdata & mask;
                    case (a)
                        0, 1, 3, 5: nxt[a] = (m_reg[a] & ~mask) | wb;
                        4: nxt[4] = m_reg[4] & ~wb;
                        6: nxt[0] = m_reg[0] | wb;
                        7: nxt[0] = m_reg[0] & ~wb;
                        default: ;
                    endcase
                end
                m_rdy = 1'b1;
            end else begin
                m_rdy = 1'b0;
            end
            nxt[4] = nxt[4] | evv;
            m_reg  = nxt;
            for (int k = S; k > 0; k--) pin_hist[k] = pin_hist[k-1];
            pin_hist[0] = gpio_in;
        end
    end

    always @(negedge clk) begin
        if (m_live) begin
            chk("cyc_io_ready", {31'b0, io_ready}, {31'b0, m_rdy});
            chk("cyc_io_rdata", io_rdata, m_rdata);
            chk("cyc_gpio_out", gpio_out, m_reg[0]);
            chk("cyc_gpio_oe",  gpio_oe,  m_reg[1]);
            chk("cyc_irq",      {31'b0, irq}, {31'b0, m_irq});
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic access(input logic [4:0] off, input logic [31:0] wd, input logic [3:0] st,
                          output logic [31:0] rd);
        bit got = 1'b0;
        io_addr  = {27'b0, off};
        io_wdata = wd;
        io_wstrb = st;
        io_valid = 1'b1;
        for (int i = 0; i < 8 && !got; i++) begin
            cyc(1);
            if (io_ready) got = 1'b1;
        end
        rd       = io_rdata;
        io_valid = 1'b0;
        io_wstrb = 4'b0000;
        n_checks++;
        if (got) n_pass++;
        else $display("FAIL access_timeout: offset %h got no io_ready expected a pulse", off);
        cyc(1);
    endtask

    task automatic bus_wr(input logic [4:0] off, input logic [31:0] wd, input logic [3:0] st);
        logic [31:0] d;
        access(off, wd, st, d);
    endtask

    task automatic bus_rd(input logic [4:0] off, output logic [31:0] rd);
        access(off, 32'h0, 4'b0000, rd);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        logic [31:0] v;
        logic [5:0]  pat;
        resetn = 1'b0; io_valid = 1'b0; io_addr = '0; io_wdata = '0; io_wstrb = '0; gpio_in = '0;
        cyc(3);
        resetn = 1'b1;

        for (int a = 0; a < 8; a++) begin
            bus_rd(5'(a * 4), v);
            chk($sformatf("reset_read_%0d", a), v, 32'h0);
        end

        bus_wr(5'h00, 32'hA5A5A5A5, 4'hF);
        bus_rd(5'h00, v);
        chk("out_readback", v, 32'hA5A5A5A5);
        chk("gpio_out_a5", gpio_out, 32'hA5A5A5A5);
        bus_wr(5'h04, 32'h1234F0F0, 4'b0011);
        chk("gpio_oe_strobed", gpio_oe, 32'h0000F0F0);
        bus_wr(5'h08, 32'hFFFFFFFF, 4'hF);
        bus_rd(5'h08, v);
        chk("in_read_only", v, 32'h0);

        bus_wr(5'h00, 32'h0, 4'hF);
        bus_wr(5'h00, 32'h12345678, 4'b0101);
        chk("out_byte_strobe", gpio_out, 32'h00340078);
        bus_wr(5'h18, 32'h0000FF00, 4'hF);
        chk("out_set", gpio_out, 32'h0034FF78);
        bus_rd(5'h18, v);
        chk("out_set_reads_0", v, 32'h0);
        bus_wr(5'h1C, 32'h00300008, 4'hF);
        chk("out_clr", gpio_out, 32'h0004FF70);

        io_addr = 32'h0; io_wstrb = 4'b0000; io_valid = 1'b1;
        for (int i = 0; i < 6; i++) begin
            pat[i] = io_ready;
            if (io_ready) chk($sformatf("hs_rdata_%0d", i), io_rdata, 32'h0004FF70);
            cyc(1);
        end
        io_valid = 1'b0;
        chk("hs_pattern", {26'b0, pat}, 32'h0000002A);
        cyc(1);

        bus_wr(5'h0C, 32'h1, 4'hF);
        gpio_in[0] = 1'b1;
        cyc(2);
        chk("irq_low_before_stat", {31'b0, irq}, 32'h0);
        cyc(1);
        chk("irq_low_p2", {31'b0, irq}, 32'h0);
        cyc(1);
        chk("irq_high_p3", {31'b0, irq}, 32'h1);
        bus_rd(5'h10, v);
        chk("stat_rise", v, 32'h1);
        bus_wr(5'h10, 32'h1, 4'hF);
        chk("irq_cleared", {31'b0, irq}, 32'h0);

        bus_wr(5'h14, 32'h8, 4'hF);
        gpio_in[3] = 1'b1;
        cyc(5);
        bus_rd(5'h10, v);
        chk("rise_under_fall_pol", v, 32'h0);
        gpio_in[3] = 1'b0;
        cyc(5);
        bus_rd(5'h10, v);
        chk("stat_fall", v, 32'h8);
        bus_wr(5'h10, 32'h8, 4'hF);
        bus_rd(5'h10, v);
        chk("stat_w1c", v, 32'h0);
        gpio_in[3] = 1'b1;
        cyc(5);
        gpio_in[3] = 1'b0;
        cyc(2);
        bus_wr(5'h10, 32'h8, 4'hF);
        bus_rd(5'h10, v);
        chk("stat_set_wins", v, 32'h8);

        bus_wr(5'h00, 32'h00000055, 4'hF);
        io_addr = 32'h0; io_wdata = 32'hDEADBEEF; io_wstrb = 4'hF; io_valid = 1'b1;
        resetn = 1'b0;
        cyc(1);
        resetn = 1'b1; io_valid = 1'b0; io_wstrb = 4'b0000;
        chk("abort_no_ready_0", {31'b0, io_ready}, 32'h0);
        chk("abort_out_0", gpio_out, 32'h0);
        cyc(1);
        chk("abort_no_ready_1", {31'b0, io_ready}, 32'h0);
        chk("abort_out_1", gpio_out, 32'h0);

        gpio_in = '1;
        resetn  = 1'b0;
        cyc(3);
        resetn = 1'b1;
        cyc(8);
        bus_rd(5'h10, v);
        chk("inhibit_stat", v, 32'h0);
        bus_rd(5'h08, v);
        chk("in_all_ones", v, 32'hFFFFFFFF);
        cyc(2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
